operand_normalizer: RTL and testbench

//  Pipelined stage directly downstream of unpackermaster. Captures both unpacked operands
//  (sign, exponent, leading-zero count, fraction, flags), normalizes each fraction
//  (f << lz) and forms the unbiased signed exponent (e - lz - bias). Results go to the
//  add/mul/div datapaths through a valid/ready handshake with stall and flush support.

---
 rtl/operand_normalizer.sv | 178 +++++++++++++++++
 tb/tb_operand_normalizer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_normalizer.sv
// Two-stage operand normalizer: S1 captures unpacked operands, S2 left-justifies each
// fraction by its leading-zero count and forms the unbiased signed exponent.
module operand_normalizer #(
  parameter int EW  = 11,
  parameter int FW  = 53,
  parameter int LZW = 6,
  parameter int OEW = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           db,
  input  logic           sa,
  input  logic           sb,
  input  logic [EW-1:0]  ea,
  input  logic [EW-1:0]  eb,
  input  logic [LZW-1:0] lza,
  input  logic [LZW-1:0] lzb,
  input  logic [FW-1:0]  fa,
  input  logic [FW-1:0]  fb,
  input  logic [3:0]     fla,
  input  logic [3:0]     flb,
  input  logic [FW-1:0]  nan,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_db,
  output logic           out_sa,
  output logic           out_sb,
  output logic [OEW-1:0] out_ea,
  output logic [OEW-1:0] out_eb,
  output logic [FW-1:0]  out_fa,
  output logic [FW-1:0]  out_fb,
  output logic [3:0]     out_fla,
  output logic [3:0]     out_flb,
  output logic [FW-1:0]  out_nan,
  output logic           out_inv
);

  typedef struct packed {
    logic           s;
    logic [EW-1:0]  e;
    logic [LZW-1:0] lz;
    logic [FW-1:0]  f;
    logic [3:0]     fl;
  } opnd_t;

  typedef struct packed {
    logic           s;
    logic [OEW-1:0] e;
    logic [FW-1:0]  f;
    logic [3:0]     fl;
  } norm_t;

  // Flags are {SNAN,NAN,INF,ZERO}; zero wins over inf/nan if both are ever set.
  function automatic norm_t normalize(input opnd_t op, input logic dbl);
    norm_t          r;
    logic [OEW-1:0] bias;
    bias = dbl ? OEW'(1023) : OEW'(127);
    r.s  = op.s;
    r.fl = op.fl;
    r.f  = op.f << op.lz;
    r.e  = OEW'(op.e) - OEW'(op.lz) - bias;
    if (op.fl[0]) begin
      r.f = '0;
      r.e = '0;
    end else if (op.fl[2] || op.fl[1]) begin
      r.f = op.f;
      r.e = '1;
    end
    return r;
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic          s1_db_q, s1_db_d;
  opnd_t         s1_a_q, s1_a_d;
  opnd_t         s1_b_q, s1_b_d;
  logic [FW-1:0] s1_nan_q, s1_nan_d;

  logic          s2_valid_q, s2_valid_d;
  logic          s2_db_q, s2_db_d;
  norm_t         s2_a_q, s2_a_d;
  norm_t         s2_b_q, s2_b_d;
  logic [FW-1:0] s2_nan_q, s2_nan_d;
  logic          s2_inv_q, s2_inv_d;

  logic          s2_adv;
  logic          accept;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_db_d    = s1_db_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_nan_d   = s1_nan_q;
    s2_valid_d = s2_valid_q;
    s2_db_d    = s2_db_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    s2_nan_d   = s2_nan_q;
    s2_inv_d   = s2_inv_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_db_d    = db;
      s1_a_d     = '{s: sa, e: ea, lz: lza, f: fa, fl: fla};
      s1_b_d     = '{s: sb, e: eb, lz: lzb, f: fb, fl: flb};
      s1_nan_d   = nan;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_db_d    = s1_db_q;
      s2_a_d     = normalize(s1_a_q, s1_db_q);
      s2_b_d     = normalize(s1_b_q, s1_db_q);
      s2_nan_d   = s1_nan_q;
      s2_inv_d   = s1_a_q.fl[3] | s1_b_q.fl[3];
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // Flush drops everything in flight, even a load happening this cycle.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_db_q    <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_nan_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_db_q    <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_nan_q   <= '0;
      s2_inv_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_db_q    <= s1_db_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_nan_q   <= s1_nan_d;
      s2_valid_q <= s2_valid_d;
      s2_db_q    <= s2_db_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      s2_nan_q   <= s2_nan_d;
      s2_inv_q   <= s2_inv_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_db    = s2_db_q;
  assign out_sa    = s2_a_q.s;
  assign out_sb    = s2_b_q.s;
  assign out_ea    = s2_a_q.e;
  assign out_eb    = s2_b_q.e;
  assign out_fa    = s2_a_q.f;
  assign out_fb    = s2_b_q.f;
  assign out_fla   = s2_a_q.fl;
  assign out_flb   = s2_b_q.fl;
  assign out_nan   = s2_nan_q;
  assign out_inv   = s2_inv_q;

endmodule

// File: tb/tb_operand_normalizer.sv
// Directed bench for operand_normalizer: a table of hand-computed vectors plus
// sequences for back-to-back flow, stall, flush and asynchronous reset.
module tb_operand_normalizer;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, db, sa, sb;
  logic [10:0] ea, eb;
  logic [5:0]  lza, lzb;
  logic [52:0] fa, fb, nan;
  logic [3:0]  fla, flb;
  logic        out_valid, out_ready, out_db, out_sa, out_sb, out_inv;
  logic [12:0] out_ea, out_eb;
  logic [52:0] out_fa, out_fb, out_nan;
  logic [3:0]  out_fla, out_flb;

  int checks = 0;
  int failures = 0;

  operand_normalizer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .db(db), .sa(sa), .sb(sb), .ea(ea), .eb(eb), .lza(lza), .lzb(lzb),
    .fa(fa), .fb(fb), .fla(fla), .flb(flb), .nan(nan),
    .out_valid(out_valid), .out_ready(out_ready), .out_db(out_db),
    .out_sa(out_sa), .out_sb(out_sb), .out_ea(out_ea), .out_eb(out_eb),
    .out_fa(out_fa), .out_fb(out_fb), .out_fla(out_fla), .out_flb(out_flb),
    .out_nan(out_nan), .out_inv(out_inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        db, sa, sb;
    logic [10:0] ea, eb;
    logic [5:0]  lza, lzb;
    logic [52:0] fa, fb;
    logic [3:0]  fla, flb;
    logic [52:0] nan;
    logic [12:0] xea, xeb;
    logic [52:0] xfa, xfb;
    logic        xinv;
  } vec_t;

  function automatic vec_t mk(input logic vdb, input logic vsa, input logic vsb,
                              input logic [10:0] vea, input logic [10:0] veb,
                              input logic [5:0] vlza, input logic [5:0] vlzb,
                              input logic [52:0] vfa, input logic [52:0] vfb,
                              input logic [3:0] vfla, input logic [3:0] vflb,
                              input logic [52:0] vnan,
                              input logic [12:0] xea, input logic [12:0] xeb,
                              input logic [52:0] xfa, input logic [52:0] xfb,
                              input logic xinv);
    vec_t v;
    v.db = vdb; v.sa = vsa; v.sb = vsb; v.ea = vea; v.eb = veb;
    v.lza = vlza; v.lzb = vlzb; v.fa = vfa; v.fb = vfb;
    v.fla = vfla; v.flb = vflb; v.nan = vnan;
    v.xea = xea; v.xeb = xeb; v.xfa = xfa; v.xfb = xfb; v.xinv = xinv;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    db = v.db; sa = v.sa; sb = v.sb; ea = v.ea; eb = v.eb;
    lza = v.lza; lzb = v.lzb; fa = v.fa; fb = v.fb;
    fla = v.fla; flb = v.flb; nan = v.nan;
    in_valid = 1'b1;
  endtask

  task automatic driveSingle(input logic [10:0] e);
    db = 1'b0; sa = 1'b0; sb = 1'b0; ea = e; eb = e; lza = '0; lzb = '0;
    fa = 53'h10000000000000; fb = 53'h10000000000000;
    fla = '0; flb = '0; nan = '0;
    in_valid = 1'b1;
  endtask

  task automatic fillBoth();
    out_ready = 1'b0;
    driveSingle(11'h0A0);
    tick();
    driveSingle(11'h0A1);
    tick();
    in_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    logic [12:0] seqExp[4];
    logic [12:0] got[$];
    logic [12:0] held;
    int waited, acc, seen;

    vecs[0] = mk(1, 0, 1, 11'h400, 11'h400, 0, 0, 53'h18000000000000, 53'h18000000000000,
                 4'b0000, 4'b0000, 53'h0, 13'h0001, 13'h0001,
                 53'h18000000000000, 53'h18000000000000, 0);
    vecs[1] = mk(1, 1, 0, 11'h001, 11'h3FF, 3, 0, 53'h02000000000000, 53'h10000000000000,
                 4'b0000, 4'b0000, 53'h0, 13'h1BFF, 13'h0000,
                 53'h10000000000000, 53'h10000000000000, 0);
    vecs[2] = mk(0, 0, 0, 11'h085, 11'h07F, 0, 1, 53'h10000000000000, 53'h08000000000000,
                 4'b0000, 4'b0000, 53'h0, 13'h0006, 13'h1FFF,
                 53'h10000000000000, 53'h10000000000000, 0);
    vecs[3] = mk(1, 0, 1, 11'h7FE, 11'h001, 2, 5, 53'h18000000000000, 53'h00000000000001,
                 4'b1100, 4'b0001, 53'h18000000000000, 13'h1FFF, 13'h0000,
                 53'h18000000000000, 53'h0, 1);
    vecs[4] = mk(1, 0, 0, 11'h7FE, 11'h7FE, 0, 0, 53'h1FFFFFFFFFFFFF, 53'h10000000000000,
                 4'b0000, 4'b0010, 53'h0, 13'h03FF, 13'h1FFF,
                 53'h1FFFFFFFFFFFFF, 53'h10000000000000, 0);
    vecs[5] = mk(1, 1, 1, 11'h001, 11'h001, 52, 63, 53'h00000000000001, 53'h00000000000001,
                 4'b0000, 4'b0000, 53'h0, 13'h1BCE, 13'h1BC3,
                 53'h10000000000000, 53'h0, 0);
    vecs[6] = mk(0, 0, 1, 11'h080, 11'h0FF, 2, 0, 53'h04000000000000, 53'h18000000000001,
                 4'b0000, 4'b1100, 53'h18000000000001, 13'h1FFF, 13'h1FFF,
                 53'h10000000000000, 53'h18000000000001, 1);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    driveSingle(11'h000);
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_ea", 64'(out_ea), 64'd0);
    checkOutput("reset_out_fa", 64'(out_fa), 64'd0);
    checkOutput("reset_out_inv", 64'(out_inv), 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    // Single transactions from the table, each checked for two-cycle latency.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      tick();
      in_valid = 1'b0;
      waited = 1;
      while (!out_valid && waited < 6) begin
        tick();
        waited++;
      end
      checkOutput($sformatf("v%0d_latency", i), 64'(waited), 64'd2);
      checkOutput($sformatf("v%0d_db", i), 64'(out_db), 64'(vecs[i].db));
      checkOutput($sformatf("v%0d_sa", i), 64'(out_sa), 64'(vecs[i].sa));
      checkOutput($sformatf("v%0d_sb", i), 64'(out_sb), 64'(vecs[i].sb));
      checkOutput($sformatf("v%0d_ea", i), 64'(out_ea), 64'(vecs[i].xea));
      checkOutput($sformatf("v%0d_eb", i), 64'(out_eb), 64'(vecs[i].xeb));
      checkOutput($sformatf("v%0d_fa", i), 64'(out_fa), 64'(vecs[i].xfa));
      checkOutput($sformatf("v%0d_fb", i), 64'(out_fb), 64'(vecs[i].xfb));
      checkOutput($sformatf("v%0d_fla", i), 64'(out_fla), 64'(vecs[i].fla));
      checkOutput($sformatf("v%0d_flb", i), 64'(out_flb), 64'(vecs[i].flb));
      checkOutput($sformatf("v%0d_nan", i), 64'(out_nan), 64'(vecs[i].nan));
      checkOutput($sformatf("v%0d_inv", i), 64'(out_inv), 64'(vecs[i].xinv));
      tick();
    end

    // Four single-precision operands back to back at full rate.
    seqExp[0] = 13'd6; seqExp[1] = 13'd7; seqExp[2] = 13'd8; seqExp[3] = 13'd0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: driveSingle(11'h085);
        1: driveSingle(11'h086);
        2: driveSingle(11'h087);
        3: driveSingle(11'h07F);
        default: in_valid = 1'b0;
      endcase
      tick();
      if (c >= 1) begin
        checkOutput($sformatf("b2b%0d_valid", c - 1), 64'(out_valid), 64'd1);
        checkOutput($sformatf("b2b%0d_ea", c - 1), 64'(out_ea), 64'(seqExp[c - 1]));
      end
    end
    in_valid = 1'b0;
    tick();
    checkOutput("b2b_drained", 64'(out_valid), 64'd0);

    // Stall downstream while still offering data.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      driveSingle(11'(11'h090 + acc));
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("stall_accepts", 64'(acc), 64'd2);
    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
    held = out_ea;
    tick();
    tick();
    checkOutput("stall_held_ea", 64'(out_ea), 64'(held));
    checkOutput("stall_first_ea", 64'(out_ea), 64'd17);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) got.push_back(out_ea);
      tick();
    end
    checkOutput("stall_drain_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      checkOutput("stall_drain0", 64'(got[0]), 64'd17);
      checkOutput("stall_drain1", 64'(got[1]), 64'd18);
    end

    // Flush with both stages full, while a new operand is also offered.
    fillBoth();
    checkOutput("flush_pre_full", 64'(out_valid && !in_ready), 64'd1);
    flush = 1'b1;
    driveSingle(11'h0B0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    checkOutput("flush_no_stale", 64'(seen), 64'd0);

    // Asynchronous reset mid-cycle with both stages full.
    fillBoth();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("areset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("areset_out_ea", 64'(out_ea), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    checkOutput("areset_no_stale", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
